// File: rtl/unified_mem.sv
// unified_mem: tagged split-transaction main memory, fixed-latency loads and immediate stores.
module unified_mem #(
  parameter int XLEN            = 32,
  parameter int MEM_64BIT_LINES = 8192,
  parameter int LATENCY         = 10,
  parameter int NUM_TAGS        = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  input  logic [1:0]      proc2mem_size,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);
  localparam int IW = $clog2(MEM_64BIT_LINES);
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  logic [63:0] unified_memory [MEM_64BIT_LINES];
  logic [63:0] snap_q [16];
  logic [NUM_TAGS:1] busy_q, busy_d, held, clr, set;
  logic [LATENCY*4-1:0] pipe_q, pipe_d;
  logic [3:0] st_tag_q, st_tag_d, resp_q, resp_d, tag_q, tag_d;
  logic [3:0] comp_tag, new_tag, ld_tag;
  logic [63:0] data_q, data_d, size_mask, wmask, wdata;
  logic [XLEN-4:0] line;
  logic [IW-1:0] li;
  logic [5:0] sh;
  logic in_range, is_load, is_store, accept;
  always_comb begin
    line = proc2mem_addr[XLEN-1:3];
    li = line[IW-1:0];
    in_range = line < (XLEN-3)'(MEM_64BIT_LINES);
    is_load = in_range && proc2mem_command == CMD_LOAD;
    is_store = in_range && proc2mem_command == CMD_STORE;
    comp_tag = pipe_q[LATENCY*4-1 -: 4];
    // Tags completing or finishing a store this edge are reusable by the request on this edge.
    for (int t = 1; t <= NUM_TAGS; t++) clr[t] = comp_tag == 4'(t) || st_tag_q == 4'(t);
    held = busy_q & ~clr;
    new_tag = 4'd0;
    for (int t = NUM_TAGS; t >= 1; t--) if (!held[t]) new_tag = 4'(t);
    accept = reset && (is_load || is_store) && new_tag != 4'd0;
    for (int t = 1; t <= NUM_TAGS; t++) set[t] = accept && new_tag == 4'(t);
    busy_d = held | set;
    resp_d = accept ? new_tag : 4'd0;
    st_tag_d = accept && is_store ? new_tag : 4'd0;
    ld_tag = accept && is_load ? new_tag : 4'd0;
    pipe_d = (pipe_q << 4) | (LATENCY*4)'(ld_tag);
    tag_d = comp_tag;
    data_d = comp_tag != 4'd0 ? snap_q[comp_tag] : 64'd0;
    size_mask = proc2mem_size == 2'd0 ? 64'hFF :
                proc2mem_size == 2'd1 ? 64'hFFFF :
                proc2mem_size == 2'd2 ? 64'hFFFF_FFFF : '1;
    sh = proc2mem_size == 2'd0 ? {proc2mem_addr[2:0], 3'b0} :
         proc2mem_size == 2'd1 ? {proc2mem_addr[2:1], 4'b0} :
         proc2mem_size == 2'd2 ? {proc2mem_addr[2], 5'b0} : 6'd0;
    wmask = size_mask << sh;
    wdata = (proc2mem_data & size_mask) << sh;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      pipe_q <= '0;
      st_tag_q <= 4'd0;
      resp_q <= 4'd0;
      tag_q <= 4'd0;
      data_q <= 64'd0;
    end else begin
      busy_q <= busy_d;
      pipe_q <= pipe_d;
      st_tag_q <= st_tag_d;
      resp_q <= resp_d;
      tag_q <= tag_d;
      data_q <= data_d;
    end
  end
  // Array and load snapshots survive reset.
  always_ff @(posedge clk) begin
    if (accept && is_store) unified_memory[li] <= (unified_memory[li] & ~wmask) | wdata;
    if (accept && is_load) snap_q[new_tag] <= unified_memory[li];
  end
  assign mem2proc_response = resp_q;
  assign mem2proc_tag = tag_q;
  assign mem2proc_data = data_q;
endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: directed bench for unified_mem with a load-completion scoreboard.
module tb_unified_mem;
  localparam int LAT = 20;
  localparam int LINES = 8192;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] p_cmd = NONE, p_size = 2'd0;
  logic [31:0] p_addr = 32'd0;
  logic [63:0] p_data = 64'd0;
  logic [3:0] resp, tag;
  logic [63:0] rdata;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int due; logic [3:0] tag; logic [63:0] data;} exp_t;
  exp_t sbq[$];
  logic [63:0] mem_m [8];

  unified_mem #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr),
    .proc2mem_data(p_data), .proc2mem_size(p_size),
    .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    exp_t e;
    if (tag !== 4'd0) begin
      if (sbq.size() == 0) chk("unexpected_tag", 64'(tag), 64'd0);
      else begin
        e = sbq.pop_front();
        chk("cmpl_tag", 64'(tag), 64'(e.tag));
        chk("cmpl_data", rdata, e.data);
        chk("cmpl_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("idle_data", rdata, 64'd0);
      if (sbq.size() != 0) chk("cmpl_overdue", 64'(sbq[0].due <= cyc), 64'd0);
    end
  end

  task automatic req(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                     input logic [1:0] sz, input logic [3:0] exp_r, input string name);
    logic [2:0] l;
    p_cmd = c; p_addr = a; p_data = d; p_size = sz;
    @(posedge clk); @(negedge clk);
    chk(name, 64'(resp), 64'(exp_r));
    l = a[5:3];
    if (exp_r != 4'd0 && c == LOAD) sbq.push_back('{cyc + LAT, exp_r, mem_m[l]});
    if (exp_r != 4'd0 && c == STORE) begin
      if (sz == 2'd0) mem_m[l][8*a[2:0] +: 8] = d[7:0];
      else if (sz == 2'd1) mem_m[l][16*a[2:1] +: 16] = d[15:0];
      else if (sz == 2'd2) mem_m[l][32*a[2] +: 32] = d[31:0];
      else mem_m[l] = d;
    end
  endtask

  task automatic idle(input int n);
    p_cmd = NONE;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = (i == 0) ? 64'h0123456789ABCDEF : 64'h1111111111111111 * 64'(i);
      dut.unified_memory[i] = mem_m[i];
    end
    idle(3);
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_tag", 64'(tag), 64'd0);
    chk("rst_data", rdata, 64'd0);
    reset = 1'b1;
    idle(1);
    chk("line0_kept", dut.unified_memory[0], 64'h0123456789ABCDEF);
    req(LOAD, 32'h0, 64'd0, 2'd3, 4'd1, "ld0_resp");
    idle(1);
    chk("resp_one_cycle", 64'(resp), 64'd0);
    idle(LAT + 2);
    req(STORE, 32'h0B, 64'hAA, 2'd0, 4'd1, "st_byte");
    req(LOAD, 32'h08, 64'd0, 2'd3, 4'd1, "ld_after_byte");
    idle(LAT + 2);
    req(STORE, 32'h12, 64'h1234BEEF, 2'd1, 4'd1, "st_half");
    req(STORE, 32'h1E, 64'hCAFEF00D, 2'd2, 4'd1, "st_word");
    req(STORE, 32'h20, 64'hDEADBEEF01234567, 2'd3, 4'd1, "st_double");
    req(LOAD, 32'h10, 64'd0, 2'd0, 4'd1, "ld_half");
    req(LOAD, 32'h18, 64'd0, 2'd1, 4'd2, "ld_word");
    req(LOAD, 32'h20, 64'd0, 2'd2, 4'd3, "ld_double");
    idle(LAT + 2);
    for (int i = 0; i < 16; i++)
      req(LOAD, 32'((i % 4) * 8), 64'd0, 2'd3, (i < 15) ? 4'(i + 1) : 4'd0, "burst");
    idle(LAT - 16);
    req(LOAD, 32'h18, 64'd0, 2'd3, 4'd1, "retry_freed_tag");
    idle(LAT + 2);
    req(LOAD, 32'(LINES * 8), 64'd0, 2'd3, 4'd0, "oob_load");
    req(STORE, 32'(LINES * 8), 64'd5, 2'd3, 4'd0, "oob_store");
    req(2'd3, 32'h0, 64'd0, 2'd3, 4'd0, "cmd3");
    idle(LAT + 2);
    req(LOAD, 32'h10, 64'd0, 2'd3, 4'd1, "snap_ld");
    req(STORE, 32'h10, 64'h5555AAAA5555AAAA, 2'd3, 4'd2, "snap_st");
    idle(LAT + 2);
    req(LOAD, 32'h10, 64'd0, 2'd3, 4'd1, "new_value_ld");
    idle(LAT + 2);
    req(LOAD, 32'h0, 64'd0, 2'd3, 4'd1, "pre_rst_ld0");
    req(LOAD, 32'h8, 64'd0, 2'd3, 4'd2, "pre_rst_ld1");
    idle(3);
    reset = 1'b0;
    sbq.delete();
    idle(2);
    chk("midrst_resp", 64'(resp), 64'd0);
    chk("midrst_tag", 64'(tag), 64'd0);
    chk("midrst_data", rdata, 64'd0);
    reset = 1'b1;
    idle(LAT + 3);
    for (int i = 0; i < 15; i++)
      req(LOAD, 32'((i % 4) * 8), 64'd0, 2'd3, 4'(i + 1), "post_rst_load");
    idle(LAT + 2);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unified_mem.md
Name: unified_mem

Overview:
- Behavioural-synthesizable model of the processor's unified instruction/data main memory.
- 64-bit-line storage array behind a tagged, split-transaction bus.
- Accepts at most one load or store per cycle; returns load data a fixed number of cycles later, identified by a 4-bit tag.
- Sits on the processor's proc2mem/mem2proc bus; the bench preloads the array directly (hex image, one 64-bit word per line).

Parameters:
- XLEN, 32, address width.
- MEM_64BIT_LINES, 8192, number of 64-bit lines (64 KiB).
- LATENCY, 10, cycles from load acceptance to tag/data return (must be >=1).
- NUM_TAGS, 15, outstanding transaction tags (values 1..15; 0 means "none").

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE).
- proc2mem_addr  in  XLEN  byte address.
- proc2mem_data  in  64  store data, right-aligned for sub-doubleword sizes.
- proc2mem_size  in  2  0=BYTE, 1=HALF, 2=WORD, 3=DOUBLE (stores only).
- mem2proc_response  out  4  tag granted to the request sampled at the last edge; 0 = rejected/no request.
- mem2proc_data  out  64  load data, valid when mem2proc_tag != 0.
- mem2proc_tag  out  4  tag of the load completing this cycle; 0 = none.
- unified_memory  internal array [MEM_64BIT_LINES] of 64 bits, hierarchically accessible by name.

Behaviour:
- Reset (reset=0, async): response=0, tag=0, data=0, all tags freed, pending loads discarded. The array is NOT cleared. The same applies on reset mid-transaction.
- Line index = addr[XLEN-1:3]. A request is valid iff command is LOAD/STORE and index < MEM_64BIT_LINES.
- Request sampled at the rising edge. Registered outputs reflect it for the following cycle.
- Acceptance: valid request and a free tag exist.
  - Allocate the lowest-numbered free tag.
  - Drive mem2proc_response = tag for exactly one cycle.
- Rejection: invalid/out-of-range request, or all 15 tags busy. Response = 0, no side effects; the processor must retry.
- STORE at acceptance edge: array written immediately.
  - BYTE writes byte lane addr[2:0] from data[7:0].
  - HALF writes lanes addr[2:1]*2 +1:+0 from data[15:0].
  - WORD writes half addr[2] from data[31:0].
  - DOUBLE writes whole line.
  - Low address bits below size alignment are ignored (aligned down).
  - Store tag freed at the next edge; no completion tag is ever returned for stores.
- LOAD at acceptance: full 64-bit line snapshotted at that edge, regardless of size. A later store to the same line does not alter it.
  - Exactly LATENCY cycles after the response cycle, mem2proc_tag = its tag and mem2proc_data = snapshot for one cycle.
  - The tag is freed at that same edge and may be reallocated in the following request.
- Fixed latency plus one acceptance per cycle means at most one completion per cycle; completions occur in acceptance order.
- Outside a completion cycle, mem2proc_tag=0 and mem2proc_data holds 0.
- Simultaneous completion and new request: both proceed in the same edge. A tag freed on that edge is available to that request.
- A store and a pending load to the same line do not interact beyond the snapshot rule.

Test Plan:
- Reset low with preloaded line 0=64'h0123456789ABCDEF -> response/tag/data all 0; array line 0 unchanged after reset release.
- LOAD addr 0 in cycle N -> response=1 in cycle N+1; tag=1, data=64'h0123456789ABCDEF in cycle N+1+LATENCY; tag 0 at all other cycles.
- STORE size BYTE addr 0x0B data 0xAA, then LOAD addr 0x08 -> returned line has byte 3 = 0xAA, others unchanged. STORE DOUBLE then LOAD returns the full stored value.
- Issue 16 back-to-back LOADs -> responses 1..15, 16th gets 0; after the first completion, a retry is granted tag 1.
- LOAD addr = MEM_64BIT_LINES*8 -> response 0, no completion ever. Command 3 -> response 0.
- LOAD line 2, next cycle STORE DOUBLE line 2 with new value -> load returns the old value. Asserting reset during the pending window -> no tag returned, all tags free afterward.
